// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: packed-beat input side and per-word output side.
interface word_serializer_if #(
  parameter int DWIDTH   = 32,
  parameter int SEL_NUM  = 2,
  parameter int WORDS_IN = 1 << SEL_NUM
);
  logic                       s_valid;
  logic                       s_ready;
  logic [DWIDTH*WORDS_IN-1:0] s_data;
  logic [SEL_NUM-1:0]         s_nwords;
  logic                       m_valid;
  logic                       m_ready;
  logic [DWIDTH-1:0]          m_data;
  logic [SEL_NUM-1:0]         m_idx;
  logic                       m_last;

  modport master (
    output s_valid, s_data, s_nwords, m_ready,
    input  s_ready, m_valid, m_data, m_idx, m_last
  );

  modport slave (
    input  s_valid, s_data, s_nwords, m_ready,
    output s_ready, m_valid, m_data, m_idx, m_last
  );
endinterface

// File: rtl/word_serializer.sv
// Splits one packed beat of WORDS_IN words into a registered one-word-per-cycle stream.
// Define WORD_SERIALIZER_MSB_FIRST_EN to emit words from the highest index down to 0.
module word_serializer #(
  parameter int DWIDTH   = 32,
  parameter int SEL_NUM  = 2,
  parameter int WORDS_IN = 1 << SEL_NUM
) (
  input logic             clk,
  input logic             rst,
  word_serializer_if.slave bus
);

  localparam logic [SEL_NUM-1:0] MAX_IDX = SEL_NUM'(WORDS_IN - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [DWIDTH*WORDS_IN-1:0] beat_r, beat_nxt_s;
  logic [SEL_NUM-1:0]         last_idx_r, last_idx_nxt_s;
  logic [SEL_NUM-1:0]         m_idx_r, m_idx_nxt_s;
  logic [DWIDTH-1:0]          m_data_r, m_data_nxt_s;
  logic                       m_last_r, m_last_nxt_s;
  logic [SEL_NUM-1:0]         nwords_s, idx_step_s;
  logic                       s_ready_s, load_s, advance_s;

  // Indices at or above WORDS_IN select nothing, so the beat is never read out of range.
  function automatic logic [DWIDTH-1:0] pick_word(
    input logic [DWIDTH*WORDS_IN-1:0] beat,
    input logic [SEL_NUM-1:0]         idx
  );
    pick_word = {DWIDTH{1'b0}};
    for (int j = 0; j < WORDS_IN; j++) begin
      if (idx == SEL_NUM'(j)) begin
        pick_word = beat[j*DWIDTH +: DWIDTH];
      end
    end
  endfunction

  assign s_ready_s = (state_r == ST_EMPTY) || (bus.m_ready && m_last_r);
  assign load_s    = bus.s_valid && s_ready_s;
  assign advance_s = (state_r == ST_BUSY) && bus.m_ready && !m_last_r;
  assign nwords_s  = (bus.s_nwords > MAX_IDX) ? MAX_IDX : bus.s_nwords;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
  assign idx_step_s = m_idx_r - SEL_NUM'(1);
`else
  assign idx_step_s = m_idx_r + SEL_NUM'(1);
`endif

  assign bus.s_ready = s_ready_s;
  assign bus.m_valid = (state_r == ST_BUSY);
  assign bus.m_data  = m_data_r;
  assign bus.m_idx   = m_idx_r;
  assign bus.m_last  = m_last_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a load on the final handshake keeps the stream bubble-free.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_s) state_nxt_s = ST_BUSY;
        else        state_nxt_s = ST_EMPTY;
      end
      ST_BUSY: begin
        if (bus.m_ready && m_last_r && !load_s) state_nxt_s = ST_EMPTY;
        else                                    state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Next values of the beat buffer and the registered output word.
  always_comb begin
    beat_nxt_s     = beat_r;
    last_idx_nxt_s = last_idx_r;
    m_idx_nxt_s    = m_idx_r;
    m_data_nxt_s   = m_data_r;
    m_last_nxt_s   = m_last_r;
    if (load_s) begin
      beat_nxt_s     = bus.s_data;
      last_idx_nxt_s = nwords_s;
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
      m_idx_nxt_s    = nwords_s;
      m_data_nxt_s   = pick_word(bus.s_data, nwords_s);
`else
      m_idx_nxt_s    = {SEL_NUM{1'b0}};
      m_data_nxt_s   = pick_word(bus.s_data, {SEL_NUM{1'b0}});
`endif
      m_last_nxt_s   = (nwords_s == {SEL_NUM{1'b0}});
    end else if (advance_s) begin
      m_idx_nxt_s  = idx_step_s;
      m_data_nxt_s = pick_word(beat_r, idx_step_s);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
      m_last_nxt_s = (idx_step_s == {SEL_NUM{1'b0}});
`else
      m_last_nxt_s = (idx_step_s == last_idx_r);
`endif
    end else begin
      m_idx_nxt_s = m_idx_r;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_r     <= {(DWIDTH*WORDS_IN){1'b0}};
      last_idx_r <= {SEL_NUM{1'b0}};
      m_idx_r    <= {SEL_NUM{1'b0}};
      m_data_r   <= {DWIDTH{1'b0}};
      m_last_r   <= 1'b0;
    end else begin
      beat_r     <= beat_nxt_s;
      last_idx_r <= last_idx_nxt_s;
      m_idx_r    <= m_idx_nxt_s;
      m_data_r   <= m_data_nxt_s;
      m_last_r   <= m_last_nxt_s;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: a 4-word instance for the main cases and a 3-word one for clamping.
module tb_word_serializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  word_serializer_if #(.DWIDTH(8), .SEL_NUM(2), .WORDS_IN(4)) ifa ();
  word_serializer_if #(.DWIDTH(8), .SEL_NUM(2), .WORDS_IN(3)) ifb ();

  word_serializer #(.DWIDTH(8), .SEL_NUM(2), .WORDS_IN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  word_serializer #(.DWIDTH(8), .SEL_NUM(2), .WORDS_IN(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Position of the k-th emitted word of a beat whose last index is n.
  function automatic int pos_of(input int k, input int n);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    return n - k;
`else
    return k;
`endif
  endfunction

  task automatic expect_word(input string tag, input bit use_b, input logic [31:0] beat,
                             input int k, input int n);
    int          pos;
    logic [7:0]  exp_d;
    logic        v, l;
    logic [7:0]  d;
    logic [1:0]  idx;
    pos   = pos_of(k, n);
    exp_d = beat[pos*8 +: 8];
    if (use_b) begin
      v = ifb.m_valid; d = ifb.m_data; idx = ifb.m_idx; l = ifb.m_last;
    end else begin
      v = ifa.m_valid; d = ifa.m_data; idx = ifa.m_idx; l = ifa.m_last;
    end
    check_eq({tag, "/m_valid"}, 32'(v), 32'd1);
    check_eq({tag, "/m_data"}, 32'(d), 32'(exp_d));
    check_eq({tag, "/m_idx"}, 32'(idx), 32'(pos));
    check_eq({tag, "/m_last"}, 32'(l), 32'(k == n));
  endtask

  task automatic send(input bit use_b, input logic [31:0] beat, input logic [1:0] n);
    if (use_b) begin
      ifb.s_valid = 1'b1; ifb.s_data = beat[23:0]; ifb.s_nwords = n; ifb.m_ready = 1'b1;
    end else begin
      ifa.s_valid = 1'b1; ifa.s_data = beat; ifa.s_nwords = n; ifa.m_ready = 1'b1;
    end
    step();
    ifa.s_valid = 1'b0;
    ifb.s_valid = 1'b0;
  endtask

  // Consume words 0..n with m_ready high, then expect the block to be idle.
  task automatic drain(input string tag, input bit use_b, input logic [31:0] beat, input int n);
    for (int k = 0; k <= n; k++) begin
      expect_word(tag, use_b, beat, k, n);
      check_eq({tag, "/s_ready"}, 32'(use_b ? ifb.s_ready : ifa.s_ready), 32'(k == n));
      step();
    end
    check_eq({tag, "/idle"}, 32'(use_b ? ifb.m_valid : ifa.m_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ifa.s_valid = 1'b0; ifa.s_data = 32'h0; ifa.s_nwords = 2'd0; ifa.m_ready = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = 24'h0; ifb.s_nwords = 2'd0; ifb.m_ready = 1'b0;
    step();
    step();
    check_eq("reset/m_valid", 32'(ifa.m_valid), 32'd0);
    check_eq("reset/m_data", 32'(ifa.m_data), 32'd0);
    check_eq("reset/m_idx", 32'(ifa.m_idx), 32'd0);
    check_eq("reset/m_last", 32'(ifa.m_last), 32'd0);
    check_eq("reset/s_ready", 32'(ifa.s_ready), 32'd1);
    check_eq("reset/b_m_valid", 32'(ifb.m_valid), 32'd0);
    rst = 1'b0;
    step();

    // Full beat.
    send(1'b0, 32'h44332211, 2'd3);
    drain("full", 1'b0, 32'h44332211, 3);
    check_eq("full/hold_data", 32'(ifa.m_data), 32'(pos_of(3, 3) == 3 ? 8'h44 : 8'h11));

    // Back-to-back beats with s_valid held high; B is presented while A is still serializing.
    ifa.s_valid = 1'b1; ifa.s_data = 32'h44332211; ifa.s_nwords = 2'd3; ifa.m_ready = 1'b1;
    step();
    ifa.s_data = 32'hDDCCBBAA;
    for (int k = 0; k <= 3; k++) begin
      expect_word("b2b_a", 1'b0, 32'h44332211, k, 3);
      check_eq("b2b_a/s_ready", 32'(ifa.s_ready), 32'(k == 3));
      step();
    end
    ifa.s_valid = 1'b0;
    ifa.s_data  = 32'h0;
    drain("b2b_b", 1'b0, 32'hDDCCBBAA, 3);

    // Partial beat with two stalled cycles on the final word.
    send(1'b0, 32'h44332211, 2'd1);
    expect_word("part0", 1'b0, 32'h44332211, 0, 1);
    step();
    ifa.m_ready = 1'b0;
    #1;
    expect_word("part1", 1'b0, 32'h44332211, 1, 1);
    check_eq("part1/s_ready_stall", 32'(ifa.s_ready), 32'd0);
    step();
    expect_word("part_stall1", 1'b0, 32'h44332211, 1, 1);
    step();
    ifa.m_ready = 1'b1;
    #1;
    expect_word("part_stall2", 1'b0, 32'h44332211, 1, 1);
    check_eq("part/s_ready_last", 32'(ifa.s_ready), 32'd1);
    step();
    check_eq("part/idle", 32'(ifa.m_valid), 32'd0);

    // Single-word beat.
    send(1'b0, 32'h44332211, 2'd0);
    drain("single", 1'b0, 32'h44332211, 0);

    // Asynchronous reset in the middle of a beat.
    send(1'b0, 32'h44332211, 2'd3);
    expect_word("rst_pre0", 1'b0, 32'h44332211, 0, 3);
    step();
    expect_word("rst_pre1", 1'b0, 32'h44332211, 1, 3);
    rst = 1'b1;
    #1;
    check_eq("rst_mid/m_valid", 32'(ifa.m_valid), 32'd0);
    check_eq("rst_mid/m_data", 32'(ifa.m_data), 32'd0);
    check_eq("rst_mid/m_idx", 32'(ifa.m_idx), 32'd0);
    check_eq("rst_mid/m_last", 32'(ifa.m_last), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("rst_post/m_valid", 32'(ifa.m_valid), 32'd0);
    check_eq("rst_post/s_ready", 32'(ifa.s_ready), 32'd1);
    send(1'b0, 32'h88776655, 2'd3);
    drain("rst_next", 1'b0, 32'h88776655, 3);

    // Clamp on the 3-word instance: s_nwords=3 behaves as 2.
    send(1'b1, 32'h00332211, 2'd3);
    drain("clamp", 1'b1, 32'h00332211, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
